// File: rtl/interval_arbiter_pkg.sv
// rtl/interval_arbiter_pkg.sv - shared types, defaults and helpers for the interval arbiter
package interval_arbiter_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_N_REQ = 2;
    localparam int MAX_REQ   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Callers truncate the result to their own requester count.
    function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/interval_arbiter_rr_pick.sv
// rtl/interval_arbiter_rr_pick.sv - combinational round-robin picker starting at ptr
module interval_arbiter_rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W:0] cand;

    // Scan from the farthest offset down so the nearest requester at or after ptr wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_i} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(N_REQ)) begin
                cand = cand - (IDX_W + 1)'(N_REQ);
            end
            if (req_i[cand[IDX_W-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/interval_arbiter.sv
// rtl/interval_arbiter.sv - round-robin owner of one shared interval counter
module interval_arbiter
    import interval_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   len,
    input  logic                     abort,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic                     aborted,
    output logic                     busy,
    output logic [WIDTH-1:0]         count
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [WIDTH-1:0]   len_q, len_d;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [WIDTH-1:0]   len_sel;
    logic [IDX_W:0]     ptr_inc;
    logic [IDX_W-1:0]   ptr_next;
    logic [N_REQ-1:0]   pick_oh;
    logic [N_REQ-1:0]   owner_oh;

    interval_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        len_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                len_sel = len[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_inc  = {1'b0, pick_idx} + (IDX_W + 1)'(1);
    assign ptr_next = (ptr_inc == (IDX_W + 1)'(N_REQ)) ? '0 : ptr_inc[IDX_W-1:0];
    assign pick_oh  = N_REQ'(onehot(3'(pick_idx)));
    assign owner_oh = N_REQ'(onehot(3'(owner_q)));

    always_comb begin
        state_d   = state_q;
        gnt_d     = '0;
        done_d    = '0;
        aborted_d = 1'b0;
        busy_d    = busy_q;
        count_d   = count_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        len_d     = len_q;
        case (state_q)
            IDLE: begin
                busy_d  = 1'b0;
                count_d = '0;
                if (pick_valid) begin
                    state_d = RUN;
                    owner_d = pick_idx;
                    len_d   = len_sel;
                    gnt_d   = pick_oh;
                    busy_d  = 1'b1;
                    ptr_d   = ptr_next;
                end
            end
            RUN: begin
                // Abort wins over terminal count; count freezes for the DONE cycle.
                if (abort) begin
                    state_d   = DONE;
                    done_d    = owner_oh;
                    aborted_d = 1'b1;
                end else if (count_q == len_q) begin
                    state_d = DONE;
                    done_d  = owner_oh;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                count_d = '0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= '0;
            ptr_q     <= '0;
            owner_q   <= '0;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            len_q     <= len_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign busy    = busy_q;
    assign count   = count_q;

endmodule

// File: tb/tb_interval_arbiter.sv
// tb/tb_interval_arbiter.sv - randomized and directed checks against an interval timeline model
module tb_interval_arbiter;

    localparam int W = 4;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] len;
    logic           abort;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           aborted;
    logic           busy;
    logic [W-1:0]   count;

    interval_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .len     (len),
        .abort   (abort),
        .gnt     (gnt),
        .done    (done),
        .aborted (aborted),
        .busy    (busy),
        .count   (count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int tcyc     = 0;

    // Model: an interval is a timeline indexed by k (k=0 is the grant cycle, k=m_d the done cycle).
    bit m_iv;
    bit m_ab;
    int m_owner, m_len, m_k, m_d, m_ptr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, tcyc, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        return N'(1 << i);
    endfunction

    task automatic model_edge(input logic rst_n, input logic [N-1:0] r,
                              input logic [N*W-1:0] l, input logic a);
        bit found;
        int w;
        if (!rst_n) begin
            m_iv  = 0;
            m_ptr = 0;
        end else if (m_iv) begin
            if (m_k == m_d) begin
                m_iv = 0;
            end else begin
                if (a) begin
                    m_d  = m_k + 1;
                    m_ab = 1;
                end
                m_k++;
            end
        end else begin
            found = 0;
            for (int s = 0; s < N; s++) begin
                w = (m_ptr + s) % N;
                if (!found && r[w]) begin
                    found   = 1;
                    m_iv    = 1;
                    m_owner = w;
                    m_len   = int'((l >> (w * W)) & ((1 << W) - 1));
                    m_k     = 0;
                    m_d     = m_len + 1;
                    m_ab    = 0;
                    m_ptr   = (w + 1) % N;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] eg, ed;
        int ec;
        bit ea, eb;
        eg = '0; ed = '0; ec = 0; ea = 0; eb = 0;
        if (m_iv) begin
            eb = 1;
            if (m_k == 0)    eg = oh(m_owner);
            if (m_k == m_d) begin
                ed = oh(m_owner);
                ea = m_ab;
            end
            ec = (m_k < m_d) ? m_k : m_d - 1;
        end
        check("gnt", 32'(gnt), 32'(eg));
        check("done", 32'(done), 32'(ed));
        check("aborted", 32'(aborted), 32'(ea));
        check("busy", 32'(busy), 32'(eb));
        check("count", 32'(count), 32'(ec));
        check("gnt_onehot0", 32'($countones(gnt) <= 1), 1);
        check("done_onehot0", 32'($countones(done) <= 1), 1);
        check("gnt_done_excl", 32'(gnt & done), 0);
    endtask

    task automatic cyc(input logic rst_n, input logic [N-1:0] r,
                       input logic [N*W-1:0] l, input logic a);
        reset = rst_n;
        req   = r;
        len   = l;
        abort = a;
        model_edge(rst_n, r, l, a);
        @(posedge clk);
        @(negedge clk);
        tcyc++;
        compare_all();
    endtask

    initial begin
        int tg, td;
        logic [N-1:0] gq[$];
        logic [N-1:0] dq[$];
        reset = 1'b0; req = '0; len = '0; abort = 1'b0;
        m_iv = 0; m_ab = 0; m_ptr = 0; m_owner = 0; m_len = 0; m_k = 0; m_d = 0;
        @(negedge clk);

        cyc(0, 2'b00, 8'h00, 0);
        cyc(0, 2'b00, 8'h00, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_count", 32'(count), 0);
        check("rst_gnt", 32'(gnt), 0);

        cyc(1, 2'b01, {4'd0, 4'd5}, 0);
        check("mr_gnt", 32'(gnt), 1);
        cyc(1, 2'b00, {4'd0, 4'd5}, 0);
        cyc(1, 2'b00, {4'd0, 4'd5}, 0);
        check("mr_count", 32'(count), 2);
        cyc(0, 2'b00, {4'd0, 4'd5}, 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_count0", 32'(count), 0);
        cyc(1, 2'b00, {4'd0, 4'd5}, 0);
        check("mr_nodone", 32'(done), 0);

        cyc(1, 2'b01, {4'd0, 4'd3}, 0);
        tg = tcyc;
        check("sg_gnt", 32'(gnt), 1);
        td = -1;
        for (int i = 0; i < 10 && td < 0; i++) begin
            cyc(1, 2'b00, {4'd0, 4'd3}, 0);
            if (done != '0) td = tcyc;
        end
        check("sg_done_seen", 32'(td >= 0), 1);
        check("sg_span", 32'(td - tg + 1), 5);
        check("sg_done", 32'(done), 1);
        check("sg_count", 32'(count), 3);
        cyc(1, 2'b00, {4'd0, 4'd3}, 0);
        check("sg_busy_fall", 32'(busy), 0);

        cyc(1, 2'b10, {4'd0, 4'd0}, 0);
        check("z_gnt", 32'(gnt), 2);
        check("z_count", 32'(count), 0);
        cyc(1, 2'b00, {4'd0, 4'd0}, 0);
        check("z_done", 32'(done), 2);
        check("z_aborted", 32'(aborted), 0);
        cyc(1, 2'b00, {4'd0, 4'd0}, 0);

        cyc(0, 2'b00, 8'h00, 0);
        for (int i = 0; i < 24; i++) begin
            cyc(1, 2'b11, {4'd2, 4'd1}, 0);
            if (gnt != '0)  gq.push_back(gnt);
            if (done != '0) dq.push_back(done);
        end
        while (gq.size() < 4) gq.push_back('0);
        while (dq.size() < 4) dq.push_back('0);
        for (int i = 0; i < 4; i++) begin
            check("rr_gnt", 32'(gq[i]), (i % 2 == 0) ? 1 : 2);
            check("rr_done", 32'(dq[i]), (i % 2 == 0) ? 1 : 2);
        end

        cyc(0, 2'b00, 8'h00, 0);
        cyc(1, 2'b01, {4'd0, 4'd15}, 0);
        for (int i = 0; i < 4; i++) cyc(1, 2'b00, {4'd0, 4'd15}, 0);
        check("ab_pre_count", 32'(count), 4);
        cyc(1, 2'b00, {4'd0, 4'd15}, 1);
        check("ab_done", 32'(done), 1);
        check("ab_aborted", 32'(aborted), 1);
        check("ab_count", 32'(count), 4);
        cyc(1, 2'b00, {4'd0, 4'd15}, 0);
        check("ab_idle", 32'(busy), 0);

        cyc(1, 2'b00, {4'd0, 4'd6}, 1);
        check("iso_idle_abort", 32'(busy), 0);
        cyc(1, 2'b01, {4'd0, 4'd6}, 0);
        check("iso_gnt", 32'(gnt), 1);
        td = -1;
        for (int i = 0; i < 12 && td < 0; i++) begin
            cyc(1, 2'b00, {4'd0, 4'd2}, 0);
            if (done != '0) td = tcyc;
        end
        check("iso_done_seen", 32'(td >= 0), 1);
        check("iso_count", 32'(count), 6);
        check("iso_aborted", 32'(aborted), 0);

        for (int i = 0; i < 3000; i++) begin
            cyc(logic'($urandom_range(0, 63) != 0), N'($urandom), (N*W)'($urandom),
                logic'($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
